// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and FSM state type for the MAC array controller
package mac_pkg;

  localparam int DW      = 8;
  localparam int K       = 8;
  localparam int COLS    = 4;
  localparam int ACC_W   = 19;
  localparam int COEF_AW = 5;
  localparam int KW      = $clog2(K);
  localparam int CNT_W   = KW + 1;
  localparam int COL_W   = $clog2(COLS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    COMPUTE,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one multiply-accumulate lane; SIGNED_MAC_EN selects two's complement arithmetic
module mac_lane
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    x,
  input  logic [DW-1:0]    c,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] w_prod_ext;

`ifdef SIGNED_MAC_EN
  logic signed [2*DW-1:0] w_xs;
  logic signed [2*DW-1:0] w_cs;
  assign w_xs       = $signed({{DW{x[DW-1]}}, x});
  assign w_cs       = $signed({{DW{c[DW-1]}}, c});
  assign w_prod     = w_xs * w_cs;
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
`else
  assign w_prod     = (2*DW)'(x) * (2*DW)'(c);
  assign w_prod_ext = {{(ACC_W-2*DW){1'b0}}, w_prod};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - four-lane MAC controller driving X buffer rotation and ROM reads (SIGNED_MAC_EN in mac_lane)
module mac_array_ctrl
  import mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               xload_done,
  input  logic [DW-1:0]      x_reg1,
  input  logic [DW-1:0]      x_reg2,
  input  logic [DW-1:0]      x_reg3,
  input  logic [DW-1:0]      x_reg4,
  output logic               x_shift,
  output logic [COEF_AW-1:0] coef_addr,
  input  logic [DW-1:0]      coef_data,
  output logic [ACC_W-1:0]   res1,
  output logic [ACC_W-1:0]   res2,
  output logic [ACC_W-1:0]   res3,
  output logic [ACC_W-1:0]   res4,
  output logic [COL_W-1:0]   res_col,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_x_shift;
  logic [COEF_AW-1:0] r_coef_addr;
  logic [COL_W-1:0]   r_res_col;
  logic               r_res_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_clr;
  logic               w_en;
  logic [DW-1:0]      w_x [4];
  logic [ACC_W-1:0]   w_acc [4];

  // Lanes accumulate only while the ROM data for k=cnt-1 is on coef_data.
  assign w_clr = (r_state == COMPUTE) && (r_cnt == '0);
  assign w_en  = (r_state == COMPUTE) && (r_cnt != '0);

  assign w_x[0] = x_reg1;
  assign w_x[1] = x_reg2;
  assign w_x[2] = x_reg3;
  assign w_x[3] = x_reg4;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mac_lane u_lane (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .en  (w_en),
      .x   (w_x[g]),
      .c   (coef_data),
      .acc (w_acc[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_cnt       <= '0;
      r_x_shift   <= 1'b0;
      r_coef_addr <= '0;
      r_res_col   <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_LOAD;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOAD: begin
          if (xload_done) begin
            r_state     <= COMPUTE;
            r_cnt       <= '0;
            r_coef_addr <= {r_col, KW'(0)};
            r_x_shift   <= 1'b0;
          end
        end
        COMPUTE: begin
          r_cnt       <= r_cnt + CNT_W'(1);
          r_coef_addr <= {r_col, r_cnt[KW-1:0] + KW'(1)};
          if (r_cnt == CNT_W'(K)) begin
            r_state     <= OUTPUT;
            r_x_shift   <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_col   <= r_col;
          end else begin
            r_x_shift <= 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_col != COL_W'(COLS - 1)) begin
              r_state     <= COMPUTE;
              r_col       <= r_col + COL_W'(1);
              r_cnt       <= '0;
              r_coef_addr <= {r_col + COL_W'(1), KW'(0)};
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Accumulators hold their final value while OUTPUT waits, so they double as result registers.
  assign res1      = w_acc[0];
  assign res2      = w_acc[1];
  assign res3      = w_acc[2];
  assign res4      = w_acc[3];
  assign res_col   = r_res_col;
  assign res_valid = r_res_valid;
  assign x_shift   = r_x_shift;
  assign coef_addr = r_coef_addr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - table-driven bench for mac_array_ctrl with X buffer and coefficient ROM models
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        xload_done;
  logic [7:0]  x_reg1, x_reg2, x_reg3, x_reg4;
  logic        x_shift;
  logic [4:0]  coef_addr;
  logic [7:0]  coef_data;
  logic [18:0] res1, res2, res3, res4;
  logic [1:0]  res_col;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mac_array_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .xload_done (xload_done),
    .x_reg1     (x_reg1),
    .x_reg2     (x_reg2),
    .x_reg3     (x_reg3),
    .x_reg4     (x_reg4),
    .x_shift    (x_shift),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .res1       (res1),
    .res2       (res2),
    .res3       (res3),
    .res4       (res4),
    .res_col    (res_col),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .done       (done)
  );

  logic [7:0] xb [4][8];
  logic [7:0] rom [32];

  assign x_reg1 = xb[0][0];
  assign x_reg2 = xb[1][0];
  assign x_reg3 = xb[2][0];
  assign x_reg4 = xb[3][0];

  always @(posedge clk) begin
    coef_data <= rom[coef_addr];
    if (x_shift) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 7; k++) xb[i][k] <= xb[i][k+1];
        xb[i][7] <= xb[i][0];
      end
    end
  end

  typedef struct packed {
    logic [3:0][7:0]        xbase;
    logic [7:0]             xstep;
    logic                   csel;
    logic [3:0][7:0]        cbase;
    logic [3:0][3:0][18:0]  exp;
  } vec_t;

  vec_t vecs [5];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
  endtask

  task automatic load_model(input int v);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++)
        xb[i][k] = vecs[v].xbase[i] + vecs[v].xstep * 8'(k);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 8; k++)
        rom[j*8+k] = (!vecs[v].csel || k == 2*j+1) ? vecs[v].cbase[j] : 8'd0;
  endtask

  task automatic run_job(input int v, input int stall_col, input int stall_len);
    int hs = 0;
    int xs = 0;
    int st = 0;
    int cyc = 0;
    bit fin = 0;
    logic [18:0] h [4];
    logic [1:0]  hcol;
    load_model(v);
    @(negedge clk);
    start = 1'b1;
    xload_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 1000) begin
      if (x_shift) xs++;
      if (done) fin = 1;
      if (res_valid && hs == stall_col && st < stall_len) begin
        if (st == 0) begin
          h[0] = res1; h[1] = res2; h[2] = res3; h[3] = res4; hcol = res_col;
        end else begin
          check($sformatf("v%0d stall%0d res_stable", v, st),
                32'({res1 == h[0], res2 == h[1], res3 == h[2], res4 == h[3], res_col == hcol}), 32'h1F);
        end
        check($sformatf("v%0d stall%0d x_shift", v, st), 32'(x_shift), 32'd0);
        res_ready = 1'b0;
        st++;
      end else begin
        res_ready = 1'b1;
        if (res_valid && hs < 4) begin
          check($sformatf("v%0d c%0d res_col", v, hs), 32'(res_col), 32'(hs));
          check($sformatf("v%0d c%0d res1", v, hs), 32'(res1), 32'(vecs[v].exp[hs][0]));
          check($sformatf("v%0d c%0d res2", v, hs), 32'(res2), 32'(vecs[v].exp[hs][1]));
          check($sformatf("v%0d c%0d res3", v, hs), 32'(res3), 32'(vecs[v].exp[hs][2]));
          check($sformatf("v%0d c%0d res4", v, hs), 32'(res4), 32'(vecs[v].exp[hs][3]));
          hs++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    xload_done = 1'b0;
    res_ready = 1'b1;
    check($sformatf("v%0d finished", v), 32'(fin), 32'd1);
    check($sformatf("v%0d handshakes", v), 32'(hs), 32'd4);
    check($sformatf("v%0d x_shift_cycles", v), 32'(xs), 32'd32);
    if (stall_len > 0) check($sformatf("v%0d stall_cycles", v), 32'(st), 32'(stall_len));
    check($sformatf("v%0d done_one_cycle", v), 32'(done), 32'd0);
    check($sformatf("v%0d idle_after", v), 32'({busy, res_valid}), 32'd0);
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].xbase = {4{8'd1}};
    vecs[0].cbase = {4{8'd1}};
    vecs[0].exp   = {16{19'd8}};

    vecs[1] = '0;
    vecs[1].xbase  = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[1].cbase  = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[1].exp[0] = {19'd32, 19'd24, 19'd16, 19'd8};
    vecs[1].exp[1] = {19'd64, 19'd48, 19'd32, 19'd16};
    vecs[1].exp[2] = {19'd96, 19'd72, 19'd48, 19'd24};
    vecs[1].exp[3] = {19'd128, 19'd96, 19'd64, 19'd32};

    vecs[2] = '0;
    vecs[2].xbase = {4{8'd255}};
    vecs[2].cbase = {4{8'd255}};
`ifdef SIGNED_MAC_EN
    vecs[2].exp   = {16{19'd8}};
`else
    vecs[2].exp   = {16{19'h7F008}};
`endif

    vecs[3] = '0;
    vecs[3].xbase = {4{8'hFF}};
    vecs[3].cbase = {4{8'h02}};
`ifdef SIGNED_MAC_EN
    vecs[3].exp   = {16{19'h7FFF0}};
`else
    vecs[3].exp   = {16{19'd4080}};
`endif

    // x[i][k] = i+1+k, coef only at k=2j+1 -> checks k alignment and full rotation
    vecs[4] = '0;
    vecs[4].xbase  = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[4].xstep  = 8'd1;
    vecs[4].csel   = 1'b1;
    vecs[4].cbase  = {4{8'd1}};
    vecs[4].exp[0] = {19'd5, 19'd4, 19'd3, 19'd2};
    vecs[4].exp[1] = {19'd7, 19'd6, 19'd5, 19'd4};
    vecs[4].exp[2] = {19'd9, 19'd8, 19'd7, 19'd6};
    vecs[4].exp[3] = {19'd11, 19'd10, 19'd9, 19'd8};

    rst = 1'b0;
    start = 1'b0;
    xload_done = 1'b0;
    res_ready = 1'b1;
    load_model(0);
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset x_shift_done", 32'({x_shift, done}), 32'd0);
    check("reset coef_addr", 32'(coef_addr), 32'd0);
    check("reset res", 32'(res1 | res2 | res3 | res4), 32'd0);
    rst = 1'b1;

    for (int v = 0; v < 5; v++) run_job(v, -1, 0);
    run_job(1, 1, 5);

    begin
      int shifts = 0;
      int cyc = 0;
      load_model(2);
      @(negedge clk);
      start = 1'b1;
      xload_done = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (shifts < 4 && cyc < 100) begin
        if (x_shift) shifts++;
        if (shifts < 4) begin
          @(negedge clk);
          cyc++;
        end
      end
      check("midrst reached cnt4", 32'(shifts), 32'd4);
      rst = 1'b0;
      #1;
      check("midrst busy_valid_done", 32'({busy, res_valid, done}), 32'd0);
      check("midrst x_shift", 32'(x_shift), 32'd0);
      check("midrst coef_addr", 32'(coef_addr), 32'd0);
      check("midrst res", 32'(res1 | res2 | res3 | res4), 32'd0);
      check("midrst res_col", 32'(res_col), 32'd0);
      @(negedge clk);
      xload_done = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst stays idle", 32'(busy), 32'd0);
    end
    run_job(1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
